// File: rtl/spi_master_engine.sv
// spi_master_engine: byte-level SPI mode-0 master (CPOL=0, CPHA=0, MSB first).
// Pops TX bytes from a FWFT FIFO, drives cs/scl/mosi, samples miso and pushes
// received bytes to the RX FIFO while the programmed RX byte count is non-zero.
// Dummy 0xFF bytes are shifted out whenever RX bytes are owed but TX is empty.
module spi_master_engine #(
    parameter int CLK_FREC = 50000000,
    parameter int SCL_FREC = 9600,
    parameter int CNT_W    = 16
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [7:0]       tx_data,
    input  logic             tx_empty,
    output logic             tx_rd,
    output logic [7:0]       rx_data,
    output logic             rx_wr,
    input  logic             rx_full,
    input  logic             len_wr,
    input  logic [CNT_W-1:0] len_wdata,
    output logic [CNT_W-1:0] rx_remaining,
    output logic             rx_overflow,
    output logic             busy,
    input  logic             miso,
    output logic             mosi,
    output logic             scl,
    output logic             cs
);

    // pclk cycles per scl half-period
    localparam int HALF = CLK_FREC / (2 * SCL_FREC);
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);

    if (HALF < 1) begin : g_half_chk
        $error("spi_master_engine: CLK_FREC/(2*SCL_FREC) must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_NEXT,
        S_TRAIL
    } state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    cnt_q, cnt_d;       // pclk count inside a half-period
    logic [3:0]       half_q, half_d;     // half-period index inside SHIFT (0..15)
    logic [7:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic             scl_q, scl_d;
    logic             mosi_q, mosi_d;
    logic             cs_q, cs_d;
    logic             rx_wr_q, rx_wr_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;

    logic             half_done;
    logic             owed;               // byte finishing in NEXT is owed to RX
    logic             load;               // start a new byte this cycle

    assign half_done = (cnt_q == HALF_LAST);

    // RX byte counter and sticky overflow; a register write beats the NEXT decrement
    always_comb begin
        rem_d = rem_q;
        ovf_d = ovf_q;
        owed  = 1'b0;
        if (state_q == S_NEXT && rem_q != '0) begin
            owed  = 1'b1;
            rem_d = rem_q - CNT_W'(1);
            if (rx_full) begin
                ovf_d = 1'b1;
            end
        end
        if (len_wr) begin
            rem_d = len_wdata;
            ovf_d = 1'b0;
        end
    end

    // FSM next state, bit timing and shift registers
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_wr_d   = 1'b0;
        rx_data_d = rx_data_q;
        load      = 1'b0;
        tx_rd     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                half_d = '0;
                if (!tx_empty || rem_q != '0) begin
                    load    = 1'b1;
                    state_d = S_LEAD;
                end
            end
            S_LEAD: begin
                if (half_done) begin
                    // first scl rise: sample bit 7 of the incoming byte
                    cnt_d   = '0;
                    half_d  = '0;
                    rx_sr_d = {rx_sr_q[6:0], miso};
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + HW'(1);
                end
            end
            S_SHIFT: begin
                if (half_done) begin
                    cnt_d = '0;
                    if (half_q == 4'd15) begin
                        state_d = S_NEXT;
                    end else begin
                        half_d = half_q + 4'd1;
                        if (half_q[0]) begin
                            // low -> high: rising edge, sample miso
                            rx_sr_d = {rx_sr_q[6:0], miso};
                        end else if (half_q != 4'd14) begin
                            // high -> low: falling edge, present next bit (not after bit 0)
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + HW'(1);
                end
            end
            S_NEXT: begin
                cnt_d  = '0;
                half_d = '0;
                if (owed && !rx_full) begin
                    rx_wr_d   = 1'b1;
                    rx_data_d = rx_sr_q;
                end
                // pending work uses the counter value after decrement / write
                if (!tx_empty || rem_d != '0) begin
                    load    = 1'b1;
                    state_d = S_LEAD;
                end else begin
                    state_d = S_TRAIL;
                end
            end
            S_TRAIL: begin
                if (half_done) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            tx_sr_d = tx_empty ? 8'hFF : tx_data;
            tx_rd   = !tx_empty && !preset;
        end
    end

    // Pin values are registered from the next state so they change cleanly on pclk
    always_comb begin
        cs_d   = (state_d == S_IDLE);
        scl_d  = (state_d == S_SHIFT) && !half_d[0];
        mosi_d = (state_d != S_IDLE) && tx_sr_d[7];
    end

    // State and datapath registers
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            half_q    <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            scl_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
            rx_wr_q   <= 1'b0;
            rx_data_q <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            scl_q     <= scl_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
            rx_wr_q   <= rx_wr_d;
            rx_data_q <= rx_data_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
        end
    end

    assign scl          = scl_q;
    assign mosi         = mosi_q;
    assign cs           = cs_q;
    assign rx_wr        = rx_wr_q;
    assign rx_data      = rx_data_q;
    assign rx_remaining = rem_q;
    assign rx_overflow  = ovf_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_master_engine.sv
// tb_spi_master_engine: table vectors, randomized frames against a byte-level
// reference model, and hand sequences for overflow, len collision and reset.
module tb_spi_master_engine;

    localparam int HALF  = 4;
    localparam int CNT_W = 16;

    logic             pclk = 1'b0;
    logic             preset = 1'b1;
    logic [7:0]       tx_data = 8'h00;
    logic             tx_empty = 1'b1;
    logic             tx_rd;
    logic [7:0]       rx_data;
    logic             rx_wr;
    logic             rx_full = 1'b0;
    logic             len_wr = 1'b0;
    logic [CNT_W-1:0] len_wdata = '0;
    logic [CNT_W-1:0] rx_remaining;
    logic             rx_overflow;
    logic             busy;
    logic             miso;
    logic             mosi;
    logic             scl;
    logic             cs;

    always #5 pclk = ~pclk;

    spi_master_engine #(.CLK_FREC(8), .SCL_FREC(1), .CNT_W(CNT_W)) dut (
        .pclk(pclk), .preset(preset),
        .tx_data(tx_data), .tx_empty(tx_empty), .tx_rd(tx_rd),
        .rx_data(rx_data), .rx_wr(rx_wr), .rx_full(rx_full),
        .len_wr(len_wr), .len_wdata(len_wdata), .rx_remaining(rx_remaining),
        .rx_overflow(rx_overflow), .busy(busy),
        .miso(miso), .mosi(mosi), .scl(scl), .cs(cs)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // TX FIFO model: txq only grows, tx_rp is the read pointer
    logic [7:0] txq[$];
    int         tx_rp = 0;
    logic [7:0] popped[$];

    always @(posedge pclk) begin
        if (tx_rd) begin
            popped.push_back(tx_data);
            tx_rp <= tx_rp + 1;
        end
    end

    always @(negedge pclk) begin
        #1;
        tx_empty = (tx_rp >= txq.size());
        tx_data  = tx_empty ? 8'h00 : txq[tx_rp];
    end

    // Slave model and bus monitor
    logic [7:0] sbytes[$];
    bit         lp = 1'b0;
    logic       sbit = 1'b0;
    bit         mbits[$];
    logic [7:0] pushes[$];
    int         rem_at_push[$];
    int         frames[$];
    int         cur_len = 0;
    int         n_busy = 0;
    bit         scl_prev = 1'b0;
    int         s_idx = 0;
    int         s_k = 0;

    assign miso = lp ? mosi : sbit;

    always @(negedge pclk) begin
        if (rx_wr) begin
            pushes.push_back(rx_data);
            rem_at_push.push_back(int'(rx_remaining));
        end
        if (busy) n_busy++;
        if (!cs) cur_len++;
        else if (cur_len > 0) begin
            frames.push_back(cur_len);
            cur_len = 0;
        end
        if (scl && !scl_prev) mbits.push_back(mosi);
        if (cs) begin
            s_idx = 0;
            s_k   = 0;
        end else if (!scl && scl_prev) begin
            if (s_k == 7) begin
                s_k = 0;
                s_idx++;
            end else s_k++;
        end
        scl_prev = scl;
        sbit = (s_idx < sbytes.size()) ? sbytes[s_idx][7-s_k] : 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Stimulus staging and expectations for one frame
    logic [7:0] stx[$];
    int         s_len;
    logic [7:0] e_pop[$];
    logic [7:0] e_mosi[$];
    logic [7:0] e_push[$];
    int         e_rem[$];
    int         e_nbytes;
    int         e_frame;

    task automatic run_and_check(input string tag);
        int pb, fb, mb, qb, ok;
        logic [7:0] b;
        pb = pushes.size(); fb = frames.size(); mb = mbits.size(); qb = popped.size();
        @(negedge pclk);
        foreach (stx[i]) txq.push_back(stx[i]);
        if (s_len != 0) begin
            len_wr    = 1'b1;
            len_wdata = CNT_W'(s_len);
        end
        @(negedge pclk);
        len_wr = 1'b0;
        ok = 0;
        for (int c = 0; c < 4000 && ok == 0; c++) begin
            @(negedge pclk);
            if (frames.size() > fb) ok = 1;
        end
        chk({tag, " frame_done"}, ok, 1);
        repeat (3) @(negedge pclk);
        chk({tag, " n_frames"}, frames.size() - fb, 1);
        if (frames.size() > fb) chk({tag, " cs_low_cycles"}, frames[fb], e_frame);
        chk({tag, " n_pops"}, popped.size() - qb, e_pop.size());
        for (int i = 0; i < e_pop.size() && qb + i < popped.size(); i++)
            chk($sformatf("%s pop%0d", tag, i), popped[qb+i], e_pop[i]);
        chk({tag, " mosi_bits"}, mbits.size() - mb, 8 * e_nbytes);
        for (int i = 0; i < e_mosi.size(); i++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++)
                if (mb + 8*i + j < mbits.size()) b = {b[6:0], mbits[mb + 8*i + j]};
            chk($sformatf("%s mosi_byte%0d", tag, i), b, e_mosi[i]);
        end
        chk({tag, " n_pushes"}, pushes.size() - pb, e_push.size());
        for (int i = 0; i < e_push.size() && pb + i < pushes.size(); i++) begin
            chk($sformatf("%s push%0d", tag, i), pushes[pb+i], e_push[i]);
            chk($sformatf("%s rem_at_push%0d", tag, i), rem_at_push[pb+i], e_rem[i]);
        end
        chk({tag, " rem_end"}, rx_remaining, 0);
        chk({tag, " busy_end"}, busy, 0);
        chk({tag, " cs_end"}, cs, 1);
    endtask

    typedef struct {
        int         ntx;
        logic [7:0] base;
        int         len;
        bit         lp;
        logic [7:0] s0;
        logic [7:0] s1;
        int         nbytes;
        logic [7:0] mosi0;
        int         npush;
        logic [7:0] p0;
        logic [7:0] p1;
        int         r0;
        int         r1;
        int         frame;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[3];
        int   nb, pb, qb, ok;
        int   n, L, N;
        logic [7:0] mby, rcv;

        // TX only 0xA5 / RX only 2 bytes / full duplex 16 bytes loopback with len=1
        vecs[0] = '{1,  8'hA5, 0, 1'b0, 8'h00, 8'h00, 1,  8'hA5, 0, 8'h00, 8'h00, 0, 0, 73};
        vecs[1] = '{0,  8'h00, 2, 1'b0, 8'h3C, 8'hC3, 2,  8'hFF, 2, 8'h3C, 8'hC3, 1, 0, 142};
        vecs[2] = '{16, 8'h20, 1, 1'b1, 8'h00, 8'h00, 16, 8'h20, 1, 8'h20, 8'h00, 0, 0, 1108};

        // Reset with no work
        repeat (2) @(negedge pclk);
        chk("rst cs", cs, 1);
        chk("rst scl", scl, 0);
        chk("rst mosi", mosi, 0);
        chk("rst tx_rd", tx_rd, 0);
        chk("rst rx_wr", rx_wr, 0);
        chk("rst rx_data", rx_data, 0);
        chk("rst rx_remaining", rx_remaining, 0);
        chk("rst rx_overflow", rx_overflow, 0);
        chk("rst busy", busy, 0);
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        nb = n_busy; qb = popped.size(); pb = pushes.size();
        repeat (20) @(negedge pclk);
        chk("idle busy_cycles", n_busy - nb, 0);
        chk("idle pops", popped.size() - qb, 0);
        chk("idle pushes", pushes.size() - pb, 0);
        chk("idle cs", cs, 1);
        chk("idle scl", scl, 0);

        // Table vectors
        for (int v = 0; v < 3; v++) begin
            stx.delete(); sbytes.delete(); e_pop.delete(); e_mosi.delete();
            e_push.delete(); e_rem.delete();
            for (int i = 0; i < vecs[v].ntx; i++) begin
                stx.push_back(vecs[v].base + 8'(i));
                e_pop.push_back(vecs[v].base + 8'(i));
            end
            sbytes.push_back(vecs[v].s0);
            sbytes.push_back(vecs[v].s1);
            lp       = vecs[v].lp;
            s_len    = vecs[v].len;
            e_nbytes = vecs[v].nbytes;
            e_frame  = vecs[v].frame;
            e_mosi.push_back(vecs[v].mosi0);
            if (vecs[v].npush > 0) begin e_push.push_back(vecs[v].p0); e_rem.push_back(vecs[v].r0); end
            if (vecs[v].npush > 1) begin e_push.push_back(vecs[v].p1); e_rem.push_back(vecs[v].r1); end
            run_and_check($sformatf("vec%0d", v));
        end

        // Randomized frames against the byte-level model
        for (int r = 0; r < 8; r++) begin
            stx.delete(); sbytes.delete(); e_pop.delete(); e_mosi.delete();
            e_push.delete(); e_rem.delete();
            n  = $urandom_range(0, 3);
            L  = $urandom_range(0, 3);
            if (n == 0 && L == 0) n = 1;
            lp = 1'($urandom_range(0, 1));
            N  = (n > L) ? n : L;
            for (int i = 0; i < n; i++) begin
                stx.push_back(8'($urandom));
                e_pop.push_back(stx[i]);
            end
            for (int i = 0; i < N; i++) sbytes.push_back(8'($urandom));
            for (int i = 0; i < N; i++) begin
                mby = (i < n) ? stx[i] : 8'hFF;
                e_mosi.push_back(mby);
                rcv = lp ? mby : sbytes[i];
                if (i < L) begin
                    e_push.push_back(rcv);
                    e_rem.push_back(L - 1 - i);
                end
            end
            s_len    = L;
            e_nbytes = N;
            e_frame  = 18*HALF + 1 + (N - 1) * (17*HALF + 1);
            run_and_check($sformatf("rnd%0d", r));
        end

        // Overflow on first byte, len write colliding with second NEXT, then reset mid-byte
        sbytes.delete();
        sbytes.push_back(8'h5A); sbytes.push_back(8'h96); sbytes.push_back(8'h11);
        sbytes.push_back(8'h22); sbytes.push_back(8'h33); sbytes.push_back(8'h44);
        lp = 1'b0;
        pb = pushes.size();
        rx_full = 1'b1;
        @(negedge pclk);
        len_wr = 1'b1; len_wdata = 16'd2;
        @(negedge pclk);
        len_wr = 1'b0;
        ok = 0;
        for (int c = 0; c < 20 && ok == 0; c++) begin
            if (!cs) ok = 1;
            else @(negedge pclk);
        end
        chk("ovf cs_fall", ok, 1);
        repeat (68) @(negedge pclk);               // NEXT of byte 0
        chk("ovf rem_before", rx_remaining, 2);
        @(negedge pclk);
        rx_full = 1'b0;
        chk("ovf overflow_set", rx_overflow, 1);
        chk("ovf rem_after", rx_remaining, 1);
        chk("ovf no_rx_wr", rx_wr, 0);
        chk("ovf dropped", pushes.size() - pb, 0);
        repeat (68) @(negedge pclk);               // NEXT of byte 1
        chk("coll rem_before", rx_remaining, 1);
        len_wr = 1'b1; len_wdata = 16'd5;
        @(negedge pclk);
        len_wr = 1'b0;
        chk("coll rx_wr", rx_wr, 1);
        chk("coll rx_data", rx_data, 8'h96);
        chk("coll rem", rx_remaining, 5);
        chk("coll overflow_clr", rx_overflow, 0);
        chk("coll cs_low", cs, 0);
        chk("coll busy", busy, 1);
        repeat (30) @(negedge pclk);               // fourth bit of byte 2, scl high
        chk("midrst scl_before", scl, 1);
        #2 preset = 1'b1;
        #1;
        chk("midrst cs", cs, 1);
        chk("midrst scl", scl, 0);
        chk("midrst busy", busy, 0);
        chk("midrst rx_wr", rx_wr, 0);
        chk("midrst mosi", mosi, 0);
        chk("midrst rem", rx_remaining, 0);
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        nb = n_busy;
        repeat (40) @(negedge pclk);
        chk("midrst pushes_total", pushes.size() - pb, 1);
        chk("midrst stays_idle", n_busy - nb, 0);
        chk("midrst cs_idle", cs, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
